// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - round-robin packet arbiter, locks a requester until tail or watchdog release
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   reqs_in[N]         per-requester flit request (level)
//   tails_in[N]        per-requester last-flit flag, qualified by reqs_in
//   datas_in[N*DATA_W] flattened flit data, requester i at [i*DATA_W +: DATA_W]
//   acks_in[N]         per-requester acknowledge back to the requesters
//   req_out            forwarded request to the consumer
//   ack_out            consumer acknowledge
//   data_out           data of the locked requester (zero when idle)
//   selected           index of the granted requester
//   timeout_pulse      one-cycle pulse after a watchdog release
module packet_arbiter #(
    parameter int N       = 5,
    parameter int SEL_W   = 3,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        reqs_in,
    input  logic [N-1:0]        tails_in,
    input  logic [N*DATA_W-1:0] datas_in,
    output logic [N-1:0]        acks_in,
    output logic                req_out,
    input  logic                ack_out,
    output logic [DATA_W-1:0]   data_out,
    output logic [SEL_W-1:0]    selected,
    output logic                timeout_pulse
);

    // A zero TIMEOUT still needs a legal one-bit counter.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);
    localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [CNT_W-1:0]   r_stall;
    logic [CNT_W-1:0]   w_stall_nxt;
    logic               r_timeout_pulse;
    logic               w_timeout_nxt;

    logic [2*N-1:0]     w_req_dbl;
    logic [N-1:0]       w_rot;
    logic [SEL_W:0]     w_offset;
    logic [SEL_W:0]     w_sum;
    logic [SEL_W-1:0]   w_winner;
    logic               w_any_req;

    logic               w_sel_req;
    logic               w_sel_tail;
    logic [DATA_W-1:0]  w_sel_data;
    logic [SEL_W-1:0]   w_sel_inc;
    logic               w_locked;
    logic               w_xfer;
    logic               w_stall_hit;

    // Cyclic search: rotate the requests so bit k is requester (ptr+k) mod N,
    // take the lowest set bit, then map the offset back to an index.
    always_comb begin
        w_req_dbl = {reqs_in, reqs_in};
        w_rot     = N'(w_req_dbl >> r_ptr);
        w_any_req = |reqs_in;
        w_offset  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_offset = (SEL_W + 1)'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + w_offset;
        if (w_sum >= N_EXT) begin
            w_sum = w_sum - N_EXT;
        end
        w_winner = w_sum[SEL_W-1:0];
    end

    // Select the locked requester's signals with constant-index compares.
    always_comb begin
        w_sel_req  = 1'b0;
        w_sel_tail = 1'b0;
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_req  = reqs_in[i];
                w_sel_tail = tails_in[i];
                w_sel_data = datas_in[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sel_inc   = (r_sel == LAST_IDX) ? '0 : r_sel + 1'b1;
    assign w_locked    = (r_state == ST_LOCKED) && !reset;
    assign w_xfer      = (r_state == ST_LOCKED) && w_sel_req && ack_out;
    assign w_stall_hit = (TIMEOUT > 0) && (r_stall == STALL_MAX);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_sel_nxt     = r_sel;
        w_stall_nxt   = r_stall;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_sel_nxt   = w_winner;
                    w_state_nxt = ST_LOCKED;
                    w_stall_nxt = '0;
                end
            end
            ST_LOCKED: begin
                // A transfer beats the watchdog when both land in the same cycle.
                if (w_xfer) begin
                    w_stall_nxt = '0;
                    if (w_sel_tail) begin
                        w_state_nxt = ST_IDLE;
                        w_ptr_nxt   = w_sel_inc;
                    end
                end else if (w_stall_hit) begin
                    w_state_nxt   = ST_IDLE;
                    w_ptr_nxt     = w_sel_inc;
                    w_stall_nxt   = '0;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_stall_nxt = r_stall + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            r_sel           <= '0;
            r_stall         <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ptr           <= w_ptr_nxt;
            r_sel           <= w_sel_nxt;
            r_stall         <= w_stall_nxt;
            r_timeout_pulse <= w_timeout_nxt;
        end
    end

    // Outputs are gated by reset directly so they are quiet even before the
    // first reset edge has cleared the state.
    always_comb begin
        acks_in = '0;
        for (int i = 0; i < N; i++) begin
            acks_in[i] = w_locked && (r_sel == SEL_W'(i)) && ack_out && reqs_in[i];
        end
    end

    assign req_out       = w_locked && w_sel_req;
    assign data_out      = w_locked ? w_sel_data : '0;
    assign selected      = r_sel;
    assign timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - scoreboard bench for packet_arbiter with directed and random traffic
module tb_packet_arbiter;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int SW = 3;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    reqs;
    logic [N-1:0]    tails;
    logic [N*DW-1:0] datas;
    logic [N-1:0]    acks;
    logic            req_out;
    logic            ack_out;
    logic [DW-1:0]   data_out;
    logic [SW-1:0]   selected;
    logic            tp;

    always #5 clk = ~clk;

    packet_arbiter #(.N(N), .SEL_W(SW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .reqs_in       (reqs),
        .tails_in      (tails),
        .datas_in      (datas),
        .acks_in       (acks),
        .req_out       (req_out),
        .ack_out       (ack_out),
        .data_out      (data_out),
        .selected      (selected),
        .timeout_pulse (tp)
    );

    typedef struct packed {
        logic          req;
        logic [N-1:0]  acks;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
        logic          tp;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: packet-level view of the arbiter.
    bit   m_locked;
    int   m_ptr;
    int   m_sel;
    int   m_stall;
    bit   m_tp;
    int   last_xfer;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int idx);
        logic [N-1:0] t;
        t = v >> idx;
        return t[0];
    endfunction

    // Predict this cycle's outputs from current inputs, queue them, advance the
    // model across the coming edge, then move to 1 time unit after that edge.
    task automatic step();
        exp_t e;
        int   xfer_i;
        bit   found;
        e.sel  = SW'(m_sel);
        e.tp   = m_tp;
        e.req  = 1'b0;
        e.acks = '0;
        e.data = '0;
        xfer_i = -1;
        if (m_locked && !reset) begin
            e.req  = bit_of(reqs, m_sel);
            e.data = DW'(datas >> (m_sel * DW));
            if (ack_out && bit_of(reqs, m_sel)) begin
                e.acks = N'(1) << m_sel;
                xfer_i = m_sel;
            end
        end
        exp_q.push_back(e);
        if (reset) begin
            m_locked = 0; m_ptr = 0; m_sel = 0; m_stall = 0; m_tp = 0;
        end else if (!m_locked) begin
            m_tp  = 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && bit_of(reqs, (m_ptr + k) % N)) begin
                    found    = 1;
                    m_sel    = (m_ptr + k) % N;
                    m_locked = 1;
                    m_stall  = 0;
                end
            end
        end else begin
            m_tp = 0;
            if (xfer_i >= 0) begin
                m_stall = 0;
                if (bit_of(tails, m_sel)) begin
                    m_locked = 0;
                    m_ptr    = (m_sel + 1) % N;
                end
            end else if (TO > 0 && m_stall == TO - 1) begin
                m_locked = 0;
                m_ptr    = (m_sel + 1) % N;
                m_tp     = 1;
            end else begin
                m_stall++;
            end
        end
        last_xfer = xfer_i;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        reqs    = '0;
        tails   = '0;
        ack_out = 1'b0;
        step();
        reset   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            check("sb_req_out",  32'(req_out),  32'(e_mon.req));
            check("sb_acks_in",  32'(acks),     32'(e_mon.acks));
            check("sb_data_out", 32'(data_out), 32'(e_mon.data));
            check("sb_selected", 32'(selected), 32'(e_mon.sel));
            check("sb_timeout",  32'(tp),       32'(e_mon.tp));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int pend [N];
        logic [DW-1:0] cur [N];

        reset   = 1'b1;
        reqs    = '0;
        tails   = '0;
        ack_out = 1'b0;
        datas   = {$urandom, $urandom};
        @(posedge clk);
        #1;
        m_locked = 0; m_ptr = 0; m_sel = 0; m_stall = 0; m_tp = 0;

        // Reset state, and outputs held quiet while reset is asserted.
        reqs = '1; tails = '1; ack_out = 1'b1;
        #1;
        check("rst_req_out", 32'(req_out), 32'd0);
        check("rst_acks", 32'(acks), 32'd0);
        check("rst_selected", 32'(selected), 32'd0);
        check("rst_timeout", 32'(tp), 32'd0);
        step();
        reset = 1'b0;

        // Single-flit packet from requester 2, then pointer lands on 3.
        do_reset();
        reqs = 5'b00100; tails = 5'b00100; ack_out = 1'b1;
        #1;
        check("t35_idle_req", 32'(req_out), 32'd0);
        step();
        check("t35_selected", 32'(selected), 32'd2);
        check("t35_acks", 32'(acks), 32'b00100);
        check("t35_data", 32'(data_out), 32'(datas[2*DW +: DW]));
        step();
        check("t35_back_idle", 32'(req_out), 32'd0);
        reqs = 5'b11111;
        #1;
        step();
        check("t35_ptr3", 32'(selected), 32'd3);

        // All requesting, single flits: strict rotation with a bubble.
        do_reset();
        reqs = '1; tails = '1; ack_out = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t36_grant", 32'(selected), 32'(k % N));
            check("t36_ack", 32'(acks), 32'(1 << (k % N)));
            step();
            check("t36_bubble", 32'(req_out), 32'd0);
        end

        // Three-flit packet from 1 is not interleaved with 0.
        do_reset();
        reqs = 5'b00010; tails = '0; ack_out = 1'b1;
        step();
        reqs = 5'b00011;
        for (int f = 0; f < 3; f++) begin
            tails = (f == 2) ? 5'b00010 : 5'b00000;
            #1;
            check("t37_ack_r1", 32'(acks), 32'b00010);
            step();
        end
        check("t37_idle", 32'(acks), 32'd0);
        step();
        check("t37_next0", 32'(selected), 32'd0);
        check("t37_ack_r0", 32'(acks), 32'b00001);

        // Watchdog releases requester 3 after 16 stalled cycles.
        do_reset();
        reqs = 5'b01000; tails = 5'b01000; ack_out = 1'b0;
        step();
        for (int c = 0; c < 16; c++) begin
            check("t38_locked", 32'(req_out), 32'd1);
            check("t38_no_pulse", 32'(tp), 32'd0);
            step();
        end
        check("t38_pulse", 32'(tp), 32'd1);
        check("t38_idle", 32'(req_out), 32'd0);
        reqs = 5'b11001;
        #1;
        step();
        check("t38_ptr4", 32'(selected), 32'd4);
        check("t38_pulse_off", 32'(tp), 32'd0);

        // Transfer at the threshold cycle wins over the watchdog.
        do_reset();
        reqs = 5'b01000; tails = 5'b01000; ack_out = 1'b0;
        step();
        for (int c = 0; c < 15; c++) step();
        ack_out = 1'b1;
        #1;
        check("t39_ack", 32'(acks), 32'b01000);
        step();
        check("t39_no_pulse", 32'(tp), 32'd0);
        check("t39_idle", 32'(req_out), 32'd0);
        step();
        check("t39_no_pulse2", 32'(tp), 32'd0);

        // Reset mid-packet abandons it; next search starts at 0.
        do_reset();
        reqs = 5'b10000; tails = '0; ack_out = 1'b1;
        step();
        step();
        reset = 1'b1;
        #1;
        check("t40_rst_acks", 32'(acks), 32'd0);
        step();
        reset = 1'b0;
        reqs = 5'b10001;
        #1;
        check("t40_req_out", 32'(req_out), 32'd0);
        check("t40_acks", 32'(acks), 32'd0);
        check("t40_selected", 32'(selected), 32'd0);
        check("t40_data", 32'(data_out), 32'd0);
        check("t40_timeout", 32'(tp), 32'd0);
        step();
        check("t40_first0", 32'(selected), 32'd0);

        // Random traffic: packets of 1..4 flits, occasional drops, ack
        // droughts to trigger the watchdog, and rare resets.
        do_reset();
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            cur[i]  = DW'($urandom);
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] == 0 && $urandom_range(3) == 0) pend[i] = $urandom_range(4, 1);
                reqs[i]  = (pend[i] > 0) && ($urandom_range(9) != 0);
                tails[i] = (pend[i] == 1);
                datas[i*DW +: DW] = cur[i];
            end
            ack_out = ((cyc % 500) < 40) ? 1'b0 : ($urandom_range(3) != 0);
            reset   = ($urandom_range(299) == 0);
            step();
            if (last_xfer >= 0) begin
                pend[last_xfer]--;
                cur[last_xfer] = DW'($urandom);
            end
        end
        reset = 1'b0;

        @(negedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
